crc_check: RTL

// Receive-side counterpart of crc_calc: takes a framed word stream whose final CRC_SIZE/DATA_WIDTH

---
 rtl/crc_pkg.sv | 17 +
 rtl/crc_calc.sv | 65 ++++++
 rtl/crc_check.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared types and helpers for the CRC receive-check slice.
// Latency: n/a (types and elaboration-time functions only).
// Backpressure: n/a.
package crc_pkg;

    // Receive-check FSM: IDLE accumulates a frame, CHECK is the single verdict cycle.
    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } crc_state_e;

    // Decodes the "TRUE"/"FALSE" string parameters; anything other than "TRUE" reads as false.
    function automatic bit bool_str(input string s);
        return (s == "TRUE");
    endfunction

endpackage

// File: rtl/crc_calc.sv
// Word-serial CRC engine: folds one DATA_WIDTH word per valid beat into a CRC_SIZE register.
// Latency: crc_o reflects a word the cycle after its valid beat; soft_reset_i reloads INIT in one cycle.
// Backpressure: none, every valid_i beat is consumed.
// Ports: clk_i/rst_i (sync active-high), soft_reset_i (reload INIT, wins over valid_i),
//        valid_i/data_i (word in), crc_o (reflected and XORed CRC of all words since INIT).
module crc_calc
    import crc_pkg::*;
#(
    parameter logic [63:0] POLY       = 64'h8005,
    parameter int          CRC_SIZE   = 16,
    parameter int          DATA_WIDTH = 8,
    parameter logic [63:0] INIT       = 64'h0000,
    parameter string       REF_IN     = "TRUE",
    parameter string       REF_OUT    = "TRUE",
    parameter logic [63:0] XOR_OUT    = 64'hffff
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  soft_reset_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CRC_SIZE-1:0]   crc_o
);

    localparam logic [CRC_SIZE-1:0] POLY_W = POLY[CRC_SIZE-1:0];
    localparam logic [CRC_SIZE-1:0] INIT_W = INIT[CRC_SIZE-1:0];
    localparam logic [CRC_SIZE-1:0] XOR_W  = XOR_OUT[CRC_SIZE-1:0];
    localparam bit                  REFIN  = bool_str(REF_IN);
    localparam bit                  REFOUT = bool_str(REF_OUT);

    logic [CRC_SIZE-1:0] state_q;
    logic [CRC_SIZE-1:0] state_refl;

    // MSB-first shift of one word; reflected input simply means feeding the word LSB first.
    function automatic logic [CRC_SIZE-1:0] crc_step(input logic [CRC_SIZE-1:0] c,
                                                     input logic [DATA_WIDTH-1:0] d);
        logic [CRC_SIZE-1:0] r;
        logic                fb;
        r = c;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            fb = r[CRC_SIZE-1] ^ (REFIN ? d[i] : d[DATA_WIDTH-1-i]);
            r  = {r[CRC_SIZE-2:0], 1'b0};
            if (fb) begin
                r = r ^ POLY_W;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i || soft_reset_i) begin
            state_q <= INIT_W;
        end else if (valid_i) begin
            state_q <= crc_step(state_q, data_i);
        end
    end

    always_comb begin
        for (int i = 0; i < CRC_SIZE; i++) begin
            state_refl[i] = state_q[CRC_SIZE-1-i];
        end
        crc_o = (REFOUT ? state_refl : state_q) ^ XOR_W;
    end

endmodule

// File: rtl/crc_check.sv
// RX FCS checker: strips the trailing CRC_SIZE/DATA_WIDTH FCS words, forwards payload, gives one verdict per frame.
// Latency: payload word out N input beats after it arrives; verdict (done_o) 2 cycles after the last_i beat.
// Backpressure: none; valid_i gaps of any length are tolerated, back-to-back frames need no idle cycle.
// Ports: clk_i/rst_i (sync active-high); valid_i/data_i/last_i frame in (last_i on final FCS word);
//        valid_o/data_o/last_o payload out; done_o+crc_ok_o/crc_err_o verdict pulse; frame_err_o runt-frame pulse.
module crc_check
    import crc_pkg::*;
#(
    parameter logic [63:0] POLY          = 64'h8005,
    parameter int          CRC_SIZE      = 16,
    parameter int          DATA_WIDTH    = 8,
    parameter logic [63:0] INIT          = 64'h0000,
    parameter string       REF_IN        = "TRUE",
    parameter string       REF_OUT       = "TRUE",
    parameter logic [63:0] XOR_OUT       = 64'hffff,
    parameter string       FCS_LSW_FIRST = "TRUE"
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic                  done_o,
    output logic                  crc_ok_o,
    output logic                  crc_err_o,
    output logic                  frame_err_o
);

    localparam int             N         = CRC_SIZE / DATA_WIDTH;
    localparam int             CW        = $clog2(N + 1);
    localparam logic [CW-1:0]  N_CNT     = CW'(N);
    localparam bit             LSW_FIRST = bool_str(FCS_LSW_FIRST);

    if ((CRC_SIZE % DATA_WIDTH) != 0 || CRC_SIZE > 64) begin : g_bad_params
        $error("crc_check: CRC_SIZE must be a multiple of DATA_WIDTH and at most 64");
    end

    crc_state_e            state_q, state_d;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] line_q    [N];
    logic [DATA_WIDTH-1:0] line_push [N];
    logic [CRC_SIZE-1:0]   fcs_q;
    logic [CRC_SIZE-1:0]   fcs_nxt;
    logic [CRC_SIZE-1:0]   crc_val;
    logic                  full;
    logic                  pop;
    logic                  is_check;
    logic                  soft_rst;

    // line_q[N-1] is the newest word; valid words sit in the top count_q slots, so when full the
    // oldest is always line_q[0].
    assign full     = (count_q == N_CNT);
    assign pop      = valid_i && full;
    assign is_check = (state_q == CHECK);

    // Line contents as they will be after this beat's push; on the last beat this is exactly the FCS.
    always_comb begin
        for (int i = 0; i < N - 1; i++) begin
            line_push[i] = line_q[i+1];
        end
        line_push[N-1] = data_i;
        fcs_nxt = '0;
        for (int i = 0; i < N; i++) begin
            if (LSW_FIRST) begin
                fcs_nxt[i*DATA_WIDTH +: DATA_WIDTH] = line_push[i];
            end else begin
                fcs_nxt[(N-1-i)*DATA_WIDTH +: DATA_WIDTH] = line_push[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Runt frames never leave IDLE; they only reset the CRC so the next frame starts from INIT.
    always_comb begin
        state_d  = state_q;
        soft_rst = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_i && last_i) begin
                    if (full) begin
                        state_d = CHECK;
                    end else begin
                        soft_rst = 1'b1;
                    end
                end
            end
            CHECK: begin
                state_d  = IDLE;
                soft_rst = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q     <= '0;
            for (int i = 0; i < N; i++) begin
                line_q[i] <= '0;
            end
            fcs_q       <= '0;
            valid_o     <= 1'b0;
            data_o      <= '0;
            last_o      <= 1'b0;
            done_o      <= 1'b0;
            crc_ok_o    <= 1'b0;
            crc_err_o   <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            valid_o     <= pop;
            data_o      <= pop ? line_q[0] : '0;
            last_o      <= pop && last_i;
            done_o      <= is_check;
            crc_ok_o    <= is_check && (crc_val == fcs_q);
            crc_err_o   <= is_check && (crc_val != fcs_q);
            frame_err_o <= valid_i && last_i && !full;
            if (valid_i) begin
                if (last_i) begin
                    count_q <= '0;
                    for (int i = 0; i < N; i++) begin
                        line_q[i] <= '0;
                    end
                    if (full) begin
                        fcs_q <= fcs_nxt;
                    end
                end else begin
                    for (int i = 0; i < N; i++) begin
                        line_q[i] <= line_push[i];
                    end
                    if (!full) begin
                        count_q <= count_q + CW'(1);
                    end
                end
            end
        end
    end

    // Fed from the pop itself (not the registered output) so the CRC already covers the final
    // payload word during CHECK.
    crc_calc #(
        .POLY       (POLY),
        .CRC_SIZE   (CRC_SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT       (INIT),
        .REF_IN     (REF_IN),
        .REF_OUT    (REF_OUT),
        .XOR_OUT    (XOR_OUT)
    ) u_crc_calc (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .soft_reset_i (soft_rst),
        .valid_i      (pop),
        .data_i       (line_q[0]),
        .crc_o        (crc_val)
    );

endmodule
